// File: rtl/reg_universal_pkg.sv
// reg_universal_pkg: mode encodings and sizing helper for the universal register
package reg_universal_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic int count_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/reg_universal_param_contador.sv
// contador_desplazamientos: counts shifts within a frame and pulses frame_done on the WIDTH-th
module contador_desplazamientos
    import reg_universal_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_async,
    input  logic                        clear,
    input  logic                        load,
    input  logic                        shift_en,
    output logic [count_w(WIDTH)-1:0]   shift_count,
    output logic                        frame_done
);
    localparam int CW = count_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // clear and load both start a fresh frame; the last shift of a frame wraps and pulses
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            shift_count <= '0;
            frame_done  <= 1'b0;
        end else if (clear || load) begin
            shift_count <= '0;
            frame_done  <= 1'b0;
        end else if (shift_en) begin
            shift_count <= (shift_count == LAST) ? '0 : shift_count + 1'b1;
            frame_done  <= (shift_count == LAST);
        end else begin
            frame_done  <= 1'b0;
        end
    end
endmodule

// File: rtl/reg_universal_param.sv
// reg_universal_param: WIDTH-bit hold/shift/load register with frame counter
module reg_universal_param
    import reg_universal_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        reset_async,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [1:0]                  mode,
    input  logic                        serial_in_left,
    input  logic                        serial_in_right,
    input  logic [WIDTH-1:0]            data_in,
    output logic [WIDTH-1:0]            q,
    output logic                        serial_out_msb,
    output logic                        serial_out_lsb,
    output logic [count_w(WIDTH)-1:0]   shift_count,
    output logic                        frame_done
);
    logic [WIDTH-1:0] q_next;
    logic             shift_en;
    logic             load;

    assign shift_en       = enable && (mode == MODE_SHR || mode == MODE_SHL);
    assign load           = enable && (mode == MODE_LOAD);
    assign serial_out_msb = q[WIDTH-1];
    assign serial_out_lsb = q[0];

    // next word from mode decode; disabled or hold mode keeps the current word
    always_comb begin
        q_next = !enable             ? q :
                 mode == MODE_SHR    ? {serial_in_left, q[WIDTH-1:1]} :
                 mode == MODE_SHL    ? {q[WIDTH-2:0], serial_in_right} :
                 mode == MODE_LOAD   ? data_in : q;
    end

    // data register: async reset, then synchronous clear, then mode result
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) q <= RESET_VALUE;
        else if (clear)   q <= RESET_VALUE;
        else              q <= q_next;
    end

    contador_desplazamientos #(.WIDTH(WIDTH)) u_cnt (
        .clk         (clk),
        .reset_async (reset_async),
        .clear       (clear),
        .load        (load),
        .shift_en    (shift_en),
        .shift_count (shift_count),
        .frame_done  (frame_done)
    );
endmodule
